dffram_arbiter: RTL

Two-requester arbiter and access sequencer for the single-port 2048-word DFFRAM. It shares one RAM port between an instruction-fetch requester (port 0, read-only) and a load/store requester (port 1, read/write with byte strobes). It converts byte addresses to word indices, range-checks them, and registers the RAM command and response. Sits between the RISC-V core fetch/LSU and the RAM macro.

---
 rtl/dffram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dffram_arbiter.sv
// Two-port arbiter and access sequencer for the single-port 2048-word DFFRAM.
// Round-robin by default; define DFFRAM_ARB_FETCH_PRIO_EN for fixed fetch priority.
module dffram_arbiter #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH          = 2048
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic                      m0_req,
  input  logic [ADDRESS_LENGTH-1:0] m0_addr,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [DATA_LENGTH-1:0]    m0_rdata,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic [3:0]                m1_we,
  input  logic [ADDRESS_LENGTH-1:0] m1_addr,
  input  logic [DATA_LENGTH-1:0]    m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [DATA_LENGTH-1:0]    m1_rdata,
  output logic                      m1_err,
  output logic                      ram_EN,
  output logic [3:0]                ram_WE,
  output logic [ADDRESS_LENGTH-1:0] ram_A,
  output logic [DATA_LENGTH-1:0]    ram_Di,
  input  logic [DATA_LENGTH-1:0]    ram_Do
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDRESS_LENGTH:0] LIMIT = (ADDRESS_LENGTH+1)'(DEPTH * 4);

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDRESS_LENGTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Compare one bit wider so DEPTH*4 cannot wrap at the top of the address space.
  function automatic logic out_of_range(input logic [ADDRESS_LENGTH-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  logic                      accept_p0;
  logic [ADDRESS_LENGTH-1:0] addr_p0;

  logic                      vld_p1;
  logic                      port_p1;
  logic                      err_p1;
  logic [IDX_W-1:0]          idx_p1;
  logic [3:0]                we_p1;
  logic [DATA_LENGTH-1:0]    wdata_p1;
  logic [DATA_LENGTH-1:0]    rdata_p1;

  // ---- stage p0: arbitration (combinational grant) ----
`ifdef DFFRAM_ARB_FETCH_PRIO_EN
  always_comb begin
    m0_gnt = m0_req;
    m1_gnt = m1_req & ~m0_req;
  end
`else
  logic ptr;  // last-granted port; resets to 1 so port 0 wins first contention

  always_comb begin
    m0_gnt = m0_req;
    m1_gnt = m1_req;
    if (m0_req && m1_req) begin
      m0_gnt = ptr;
      m1_gnt = ~ptr;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr <= 1'b1;
    end else if (accept_p0) begin
      ptr <= m1_gnt;
    end
  end
`endif

  assign accept_p0 = m0_gnt | m1_gnt;
  assign addr_p0   = m1_gnt ? m1_addr : m0_addr;

  // ---- stage p1: command register ----
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_p1  <= 1'b0;
      port_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        port_p1 <= m1_gnt;
        err_p1  <= out_of_range(addr_p0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept_p0) begin
      idx_p1   <= word_index(addr_p0);
      we_p1    <= m1_gnt ? m1_we : 4'b0000;
      wdata_p1 <= m1_gnt ? m1_wdata : '0;
    end
  end

  always_comb begin
    ram_EN = vld_p1 & ~err_p1;
    ram_WE = ram_EN ? we_p1 : 4'b0000;
    ram_A  = ram_EN ? ADDRESS_LENGTH'(idx_p1) : '0;
    ram_Di = ram_EN ? wdata_p1 : '0;
  end

  // Writes and rejected accesses answer with zero data.
  assign rdata_p1 = (err_p1 || (we_p1 != 4'b0000)) ? '0 : ram_Do;

  // ---- stage p2: response register ----
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= vld_p1 & ~port_p1;
      m0_err    <= vld_p1 & ~port_p1 & err_p1;
      m1_rvalid <= vld_p1 & port_p1;
      m1_err    <= vld_p1 & port_p1 & err_p1;
      if (vld_p1 && !port_p1) m0_rdata <= rdata_p1;
      if (vld_p1 && port_p1)  m1_rdata <= rdata_p1;
    end
  end

endmodule
